rf_read_arbiter: RTL and testbench

Shares the single 32-entry x 32-bit register-file read port (the 5-bit-select, 32-bit read mux) between NREQ requesters.
- Grants one requester per cycle using round-robin priority.
- Drives the read select and registers the returned data with 1-cycle latency.
- Returns zero for register 0 and forwards same-cycle write-port data (bypass).
- Sits between the pipeline stages and the register file.

---
 rtl/rf_read_arbiter_if.sv | 23 ++
 rtl/rf_read_arbiter.sv | 91 +++++++++
 tb/tb_rf_read_arbiter.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/rf_read_arbiter_if.sv
// Request/response bundle between pipeline requesters and the shared
// register-file read port arbiter.
interface rf_read_arbiter_if #(
    parameter int NREQ = 4,
    parameter int PW   = 2
);
    logic [NREQ-1:0]   req_valid;
    logic [5*NREQ-1:0] req_addr;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ-1:0]   rsp_valid;
    logic [PW-1:0]     rsp_id;
    logic [31:0]       rsp_data;

    modport master (
        output req_valid, req_addr,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_addr,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/rf_read_arbiter.sv
// Round-robin arbiter sharing one 32x32 register-file read port among NREQ
// requesters, with r0 forced to zero, write bypass and a one-cycle response.
module rf_read_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                hold,
    rf_read_arbiter_if.slave    bus,
    output logic [4:0]          rf_sel,
    input  logic [31:0]         rf_rdata,
    input  logic                wr_en,
    input  logic [4:0]          wr_addr,
    input  logic [31:0]         wr_data
);

    logic [PW-1:0]   ptr;
    logic [PW-1:0]   win;
    logic            found;
    logic            grant;
    logic [PW:0]     scan_idx;
    logic [4:0]      addr_arr [NREQ];
    logic [4:0]      win_addr;
    logic [31:0]     result;
    logic [NREQ-1:0] win_onehot;
    logic [PW-1:0]   ptr_next;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i] = bus.req_addr[5*i +: 5];
        end
    end

    // Scan from ptr upward with wrap; the first valid index wins.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update,
        // otherwise the tool infers a latch to hold the old value.
        found    = 1'b0;
        win      = '0;
        scan_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan_idx = {1'b0, ptr} + (PW+1)'(k);
            if (scan_idx >= (PW+1)'(NREQ)) begin
                scan_idx = scan_idx - (PW+1)'(NREQ);
            end
            if (!found && bus.req_valid[scan_idx[PW-1:0]]) begin
                found = 1'b1;
                win   = scan_idx[PW-1:0];
            end
        end
    end

    assign grant      = found && !hold;
    assign win_onehot = NREQ'(1) << win;
    assign win_addr   = addr_arr[win];

    assign bus.req_ready = grant ? win_onehot : '0;
    assign rf_sel        = grant ? win_addr : 5'd0;

    // r0 beats the bypass so a write to r0 can never leak through.
    always_comb begin
        result = rf_rdata;
        if (win_addr == 5'd0) begin
            result = 32'd0;
        end else if (wr_en && (wr_addr == win_addr)) begin
            result = wr_data;
        end
    end

    assign ptr_next = (win == PW'(NREQ-1)) ? '0 : win + PW'(1);

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr           <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_id    <= '0;
            bus.rsp_data  <= '0;
        end else begin
            bus.rsp_valid <= grant ? win_onehot : '0;
            if (grant) begin
                ptr          <= ptr_next;
                bus.rsp_id   <= win;
                bus.rsp_data <= result;
            end
        end
    end

endmodule

// File: tb/tb_rf_read_arbiter.sv
// Directed bench for rf_read_arbiter with NREQ=4: round-robin, async reset,
// r0, bypass, hold and sparse wrap scenarios against hand-computed values.
module tb_rf_read_arbiter;

    logic        clk;
    logic        rst_n;
    logic        hold;
    logic [4:0]  rf_sel;
    logic [31:0] rf_rdata;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] rf_mem [32];

    int n_checks = 0;
    int n_fail   = 0;

    rf_read_arbiter_if #(.NREQ(4), .PW(2)) bus ();

    rf_read_arbiter #(.NREQ(4), .PW(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (hold),
        .bus      (bus),
        .rf_sel   (rf_sel),
        .rf_rdata (rf_rdata),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file: combinational read mux, write on the clock edge.
    assign rf_rdata = rf_mem[rf_sel];
    always @(posedge clk) begin
        if (wr_en && wr_addr != 5'd0) rf_mem[wr_addr] <= wr_data;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [19:0] addrs(input logic [4:0] a3, a2, a1, a0);
        return {a3, a2, a1, a0};
    endfunction

    // Inputs are already applied; check the grant, cross the edge, check the response.
    task automatic cycle(input string tag, input logic [3:0] exp_ready, input logic [4:0] exp_sel,
                         input logic [3:0] exp_rv, input logic [1:0] exp_id, input logic [31:0] exp_data);
        #1;
        check({tag, ".req_ready"}, 32'(bus.req_ready), 32'(exp_ready));
        check({tag, ".rf_sel"},    32'(rf_sel),        32'(exp_sel));
        @(posedge clk);
        #1;
        check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(exp_rv));
        check({tag, ".rsp_id"},    32'(bus.rsp_id),    32'(exp_id));
        check({tag, ".rsp_data"},  bus.rsp_data,       exp_data);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  w;
        logic [3:0]  oh;

        for (int i = 0; i < 32; i++) rf_mem[i] = 32'd0;
        rf_mem[1]  = 32'h11; rf_mem[2] = 32'h22; rf_mem[3] = 32'h33; rf_mem[4] = 32'h44;
        rf_mem[7]  = 32'h5;  rf_mem[8] = 32'h88; rf_mem[9] = 32'h99; rf_mem[10] = 32'hAA;

        rst_n         = 1'b0;
        hold          = 1'b0;
        wr_en         = 1'b0;
        wr_addr       = 5'd0;
        wr_data       = 32'd0;
        bus.req_valid = 4'b0000;
        bus.req_addr  = '0;
        #2;
        check("reset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("reset.rsp_id",    32'(bus.rsp_id),    32'd0);
        check("reset.rsp_data",  bus.rsp_data,       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin: all valid, requester i reads address i+1.
        bus.req_valid = 4'b1111;
        bus.req_addr  = addrs(5'd4, 5'd3, 5'd2, 5'd1);
        for (int k = 0; k < 5; k++) begin
            w  = 4'(k % 4);
            oh = 4'b0001 << w;
            cycle($sformatf("rr%0d", k), oh, 5'(w + 1), oh, 2'(w), 32'h11 * (32'(w) + 1));
        end

        // Async reset mid-stream with a grant pending (ptr is 1 here).
        #2;
        rst_n = 1'b0;
        #1;
        check("areset.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("areset.rsp_data",  bus.rsp_data,       32'd0);
        check("areset.rsp_id",    32'(bus.rsp_id),    32'd0);
        bus.req_valid = 4'b0011;
        #1;
        rst_n = 1'b1;
        cycle("post_reset", 4'b0001, 5'd1, 4'b0001, 2'd0, 32'h11);

        // Register 0 reads as zero even with a write to r0 and garbage on the mux.
        rf_mem[0]     = 32'hDEADBEEF;
        bus.req_valid = 4'b0100;
        bus.req_addr  = addrs(5'd0, 5'd0, 5'd0, 5'd0);
        wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
        cycle("zero_reg", 4'b0100, 5'd0, 4'b0100, 2'd2, 32'd0);
        rf_mem[0] = 32'd0;

        // Bypass on matching write, stored value on a non-matching one.
        bus.req_valid = 4'b0010;
        bus.req_addr  = addrs(5'd0, 5'd0, 5'd7, 5'd0);
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hCAFE0001;
        cycle("bypass", 4'b0010, 5'd7, 4'b0010, 2'd1, 32'hCAFE0001);
        bus.req_addr = addrs(5'd0, 5'd0, 5'd8, 5'd0);
        cycle("no_bypass", 4'b0010, 5'd8, 4'b0010, 2'd1, 32'h88);
        wr_en = 1'b0;

        // Hold with ptr=2: nothing granted, data holds, then requester 2 first.
        bus.req_valid = 4'b1111;
        bus.req_addr  = addrs(5'd4, 5'd3, 5'd2, 5'd1);
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cycle($sformatf("hold%0d", k), 4'b0000, 5'd0, 4'b0000, 2'd1, 32'h88);
        end
        hold = 1'b0;
        cycle("hold_release", 4'b0100, 5'd3, 4'b0100, 2'd2, 32'h33);

        // Requester 0 alone moves ptr to 1.
        bus.req_valid = 4'b0001;
        bus.req_addr  = addrs(5'd10, 5'd0, 5'd0, 5'd9);
        cycle("set_ptr", 4'b0001, 5'd9, 4'b0001, 2'd0, 32'h99);

        // Sparse: only 0 and 3 valid, from ptr=1 -> 3,0,3,0.
        bus.req_valid = 4'b1001;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) cycle($sformatf("sparse%0d", k), 4'b1000, 5'd10, 4'b1000, 2'd3, 32'hAA);
            else            cycle($sformatf("sparse%0d", k), 4'b0001, 5'd9,  4'b0001, 2'd0, 32'h99);
        end

        // Idle: no grant, response deasserts, data and id hold.
        bus.req_valid = 4'b0000;
        cycle("idle", 4'b0000, 5'd0, 4'b0000, 2'd0, 32'h99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
